// File: rtl/key_code_entry.sv
// Four-key debounced entry pad: each KEY is synchronized and debounced per lane,
// and accepted presses edit a 4-bit display code (clear / load switches / inc / dec).

module kce_debounce_lane #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic key_raw,
  output logic key_db,
  output logic key_press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronized level disagrees with the
  // accepted level; any agreement, even for one cycle, restarts it.
  always_comb begin
    sync1_d  = key_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        press_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign key_db    = stable_q;
  assign key_press = press_q;

endmodule

module key_code_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [3:0] KEY_DB,
  output logic [3:0] KEY_PRESS,
  output logic [3:0] CODE,
  output logic       CODE_VALID
);

  localparam int unsigned NUM_KEYS = 4;
  localparam int unsigned CNT_W    = ($clog2(DEBOUNCE_CYCLES) > 20) ? $clog2(DEBOUNCE_CYCLES) : 20;

  typedef struct packed {
    logic [3:0] code;
    logic       valid;
  } code_state_t;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_CLEAR,
    ACT_LOAD,
    ACT_INC,
    ACT_DEC
  } act_e;

  logic [NUM_KEYS-1:0] key_db;
  logic [NUM_KEYS-1:0] key_press;
  logic [3:0]          sel;
  logic                unused_sw9;
  act_e                act;
  code_state_t         code_q, code_d;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
    kce_debounce_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_lane (
      .gclk     (CLOCK_50),
      .grst_n   (RESET_N),
      .key_raw  (KEY[i]),
      .key_db   (key_db[i]),
      .key_press(key_press[i])
    );
  end

  assign unused_sw9 = SW[9];
  assign sel        = SW[8] ? SW[7:4] : SW[3:0];

  // Only one action per cycle: KEY3 clear beats KEY0 load beats KEY1 inc beats KEY2 dec.
  always_comb begin
    act = ACT_NONE;
    if      (key_press[3]) act = ACT_CLEAR;
    else if (key_press[0]) act = ACT_LOAD;
    else if (key_press[1]) act = ACT_INC;
    else if (key_press[2]) act = ACT_DEC;
  end

  always_comb begin
    code_d = code_q;
    unique case (act)
      ACT_CLEAR: code_d = '{code: 4'h0, valid: 1'b0};
      ACT_LOAD:  code_d = '{code: sel,  valid: 1'b1};
      ACT_INC:   code_d.code = code_q.code + 4'h1;
      ACT_DEC:   code_d.code = code_q.code - 4'h1;
      default:   code_d = code_q;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) code_q <= '{code: 4'h0, valid: 1'b0};
    else          code_q <= code_d;
  end

  assign KEY_DB     = key_db;
  assign KEY_PRESS  = key_press;
  assign CODE       = code_q.code;
  assign CODE_VALID = code_q.valid;

endmodule

// File: tb/tb_key_code_entry.sv
// Bench for key_code_entry: directed key scenarios plus random key/switch activity,
// every cycle compared against a sample-window reference model.

module tb_key_code_entry;

  localparam int DB = 4;

  logic       gclk = 1'b0;
  logic       grst_n;
  logic [3:0] key;
  logic [9:0] sw;
  logic [3:0] key_db, key_press, code;
  logic       code_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int pcnt [4];

  key_code_entry #(.DEBOUNCE_CYCLES(DB)) dut (
    .CLOCK_50  (gclk),
    .RESET_N   (grst_n),
    .KEY       (key),
    .SW        (sw),
    .KEY_DB    (key_db),
    .KEY_PRESS (key_press),
    .CODE      (code),
    .CODE_VALID(code_valid)
  );

  always #5 gclk = ~gclk;

  // Reference model: a key is accepted once the last DB synchronized samples all
  // disagree with the accepted level; code actions apply one cycle after the pulse.
  logic [3:0] m_s1, m_s2, m_stable, m_press, m_code;
  logic       m_valid;
  bit         hist [4][$];

  task automatic model_reset();
    m_s1 = 4'hF; m_s2 = 4'hF; m_stable = 4'hF; m_press = 4'h0;
    m_code = 4'h0; m_valid = 1'b0;
    for (int i = 0; i < 4; i++) hist[i].delete();
  endtask

  task automatic model_step(input logic [3:0] k, input logic [9:0] s);
    logic [3:0] s2_pre;
    bit         all_diff;
    s2_pre = m_s2;
    if      (m_press[3]) begin m_code = 4'h0; m_valid = 1'b0; end
    else if (m_press[0]) begin m_code = s[8] ? s[7:4] : s[3:0]; m_valid = 1'b1; end
    else if (m_press[1]) m_code = m_code + 4'h1;
    else if (m_press[2]) m_code = m_code - 4'h1;
    m_s2 = m_s1;
    m_s1 = k;
    for (int i = 0; i < 4; i++) begin
      m_press[i] = 1'b0;
      hist[i].push_back(s2_pre[i]);
      if (hist[i].size() > DB) void'(hist[i].pop_front());
      if (hist[i].size() == DB) begin
        all_diff = 1;
        foreach (hist[i][j]) if (hist[i][j] == m_stable[i]) all_diff = 0;
        if (all_diff) begin
          m_stable[i] = ~m_stable[i];
          m_press[i]  = ~m_stable[i];
          hist[i].delete();
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".db"},    {28'h0, key_db},     {28'h0, m_stable});
    chk({tag, ".press"}, {28'h0, key_press},  {28'h0, m_press});
    chk({tag, ".code"},  {28'h0, code},       {28'h0, m_code});
    chk({tag, ".valid"}, {31'h0, code_valid}, {31'h0, m_valid});
  endtask

  task automatic cyc();
    @(posedge gclk);
    model_step(key, sw);
    #1;
    for (int i = 0; i < 4; i++) if (key_press[i] === 1'b1) pcnt[i]++;
    check_all("cyc");
  endtask

  task automatic hold(input logic [3:0] k, input int n);
    key = k;
    repeat (n) cyc();
  endtask

  task automatic press(input int idx);
    logic [3:0] k;
    k = 4'hF;
    k[idx] = 1'b0;
    hold(k, 8);
    hold(4'hF, 8);
  endtask

  task automatic clr_pcnt();
    for (int i = 0; i < 4; i++) pcnt[i] = 0;
  endtask

  // Edges from now until KEY_DB[idx] reaches val (bounded; 30 means timeout).
  task automatic wait_db(input int idx, input logic val, output int n);
    n = 0;
    while (n < 30) begin
      cyc();
      n++;
      if (key_db[idx] === val) break;
    end
    if (key_db[idx] !== val) n = 30;
  endtask

  int n;

  initial begin
    grst_n = 1'b0;
    key    = 4'hF;
    sw     = 10'h000;
    clr_pcnt();
    model_reset();
    #12;
    check_all("reset");
    grst_n = 1'b1;

    // Clean press of KEY0 loading the low nibble
    sw = 10'h0A5;
    hold(4'hF, 3);
    key = 4'b1110;
    wait_db(0, 1'b0, n);
    chk("clean.latency", n, 6);
    chk("clean.pulse", {28'h0, key_press}, 32'h1);
    cyc();
    chk("clean.code", {28'h0, code}, 32'h5);
    chk("clean.valid", {31'h0, code_valid}, 32'h1);
    hold(4'b1110, 4);
    clr_pcnt();
    hold(4'hF, 10);
    chk("clean.release_db", {28'h0, key_db}, 32'hF);
    chk("clean.release_nopulse", pcnt[0], 0);

    // Walk down to 0xF, then a bouncing KEY1 must yield exactly one increment
    repeat (6) press(2);
    chk("dec6.code", {28'h0, code}, 32'hF);
    clr_pcnt();
    repeat (5) begin hold(4'b1101, 2); hold(4'hF, 2); end
    chk("bounce.nopulse", pcnt[1], 0);
    hold(4'b1101, 10);
    hold(4'hF, 10);
    chk("bounce.one_pulse", pcnt[1], 1);
    chk("bounce.wrap", {28'h0, code}, 32'h0);

    // Decrement wrap and high-nibble select
    press(2);
    chk("wrap.code", {28'h0, code}, 32'hF);
    sw = 10'h1A5;
    press(0);
    chk("sel.code", {28'h0, code}, 32'hA);

    // Coincident pulses: clear wins over load, inc wins over dec
    hold(4'b0110, 8);
    hold(4'hF, 8);
    chk("sim30.code", {28'h0, code}, 32'h0);
    chk("sim30.valid", {31'h0, code_valid}, 32'h0);
    hold(4'b1001, 8);
    hold(4'hF, 8);
    chk("sim12.code", {28'h0, code}, 32'h1);

    // Reset while KEY0's counter sits at 2
    press(0);
    key = 4'b1110;
    repeat (4) cyc();
    grst_n = 1'b0;
    model_reset();
    #1;
    check_all("midreset");
    chk("midreset.db", {28'h0, key_db}, 32'hF);
    #1;
    grst_n = 1'b1;
    wait_db(0, 1'b0, n);
    chk("midreset.latency", n, 6);
    hold(4'hF, 8);
    chk("midreset.valid", {31'h0, code_valid}, 32'h1);

    // Random key/switch activity, mostly single-key with occasional glitches
    for (int seg = 0; seg < 300; seg++) begin
      logic [3:0] k;
      int         r;
      r = $urandom_range(0, 9);
      if (r < 4)      begin k = 4'hF; k[$urandom_range(0, 3)] = 1'b0; end
      else if (r < 7) k = 4'hF;
      else            k = 4'($urandom);
      if ($urandom_range(0, 3) == 0) sw = 10'($urandom);
      hold(k, $urandom_range(1, 9));
    end
    hold(4'hF, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_code_entry.md
KEY_CODE_ENTRY -- requirements
Module: key_code_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the number of consecutive stable clock cycles required to accept a key change (20 ms at 50 MHz); legal range 2..2^20.
REQ-002 SHALL have port CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET_N  input  1  asynchronous active-low reset.
REQ-004 SHALL have port KEY  input  4  raw active-low pushbuttons KEY[3:0], asynchronous to CLOCK_50 and bouncing.
REQ-005 SHALL have port SW  input  10  slide switches; only SW[8:0] are used.
REQ-006 SHALL have port KEY_DB  output  4  debounced active-low key levels for the downstream display stage.
REQ-007 SHALL have port KEY_PRESS  output  4  one-cycle pulse per key on each accepted press (release-to-pressed transition).
REQ-008 SHALL have port CODE  output  4  registered display code for the downstream display stage.
REQ-009 SHALL have port CODE_VALID  output  1  high once CODE has been loaded since reset or the last clear.

Function
REQ-010 SHALL pass each KEY bit through a two-flop synchronizer before any other use.
REQ-011 SHALL keep, per key, a stable level and a counter of at least 20 bits.
REQ-012 SHALL clear a key's counter in any cycle where its synchronized level equals its stable level.
REQ-013 SHALL increment the counter in each cycle where the levels differ, and SHALL load the synchronized level into the stable level and clear the counter at the edge where the counter equals DEBOUNCE_CYCLES-1.
REQ-014 SHALL therefore update KEY_DB exactly DEBOUNCE_CYCLES cycles after the synchronized level first differs, provided it does not revert; any single-cycle reversion restarts the count from zero.
REQ-015 SHALL drive KEY_DB directly from the stable levels.
REQ-016 SHALL assert KEY_PRESS[i] in the same cycle that KEY_DB[i] goes 1->0, for exactly one cycle; releases (0->1) SHALL produce no pulse.
REQ-017 SHALL form the selected nibble SEL as SW[7:4] when SW[8]=1, else SW[3:0].
REQ-018 SHALL update CODE and CODE_VALID one cycle after a KEY_PRESS pulse, using fixed priority KEY3 > KEY0 > KEY1 > KEY2 when several pulse together:
  - KEY3: CODE<=0, CODE_VALID<=0.
  - KEY0: CODE<=SEL, CODE_VALID<=1.
  - KEY1: CODE<=CODE+1, modulo 16 (15 wraps to 0); CODE_VALID unchanged.
  - KEY2: CODE<=CODE-1, modulo 16 (0 wraps to 15); CODE_VALID unchanged.
REQ-019 SHALL hold CODE and CODE_VALID in every cycle with no KEY_PRESS pulse.
REQ-020 SHALL apply only the highest-priority action when pulses coincide, with no partial or combined effect.
REQ-021 SHALL sample SEL only in the cycle the KEY0 pulse is present; SW changes at any other time SHALL have no effect.
REQ-022 SHALL debounce the four keys independently; activity on one key SHALL NOT affect another key's counter.

Reset
REQ-023 SHALL, while RESET_N=0, asynchronously force the following, regardless of clock:
  - synchronizer flops and stable levels to 1, so KEY_DB=4'b1111;
  - all counters to 0;
  - KEY_PRESS=0, CODE=0, CODE_VALID=0.
REQ-024 SHALL abandon any debounce in progress on reset assertion, mid-count included; after release, a key held low SHALL be accepted as a new press after full synchronization plus DEBOUNCE_CYCLES.
REQ-025 SHALL apply no update at the first clock edge after RESET_N deasserts, other than ordinary synchronizer sampling.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 Clean press: KEY0 held low with SW=9'h0A5 (SW[8]=0) -> KEY_DB[0]=0 and a one-cycle KEY_PRESS[0] exactly 4 cycles after the synchronized level changes; next cycle CODE=4'h5, CODE_VALID=1; on release, KEY_DB[0]=1 with no pulse.
REQ-027 Bounce: KEY1 toggles low/high every 2 cycles for 20 cycles, then stays low -> no KEY_PRESS during toggling; exactly one pulse after it settles; starting from CODE=4'hF, CODE becomes 4'h0.
REQ-028 Wrap and select: with CODE=0, press KEY2 -> CODE=4'hF; then SW=9'h1A5 (SW[8]=1) and press KEY0 -> CODE=4'hA.
REQ-029 Simultaneous: KEY3 and KEY0 pulse in the same cycle -> CODE=0, CODE_VALID=0; KEY1 and KEY2 pulse together -> CODE increments by 1.
REQ-030 Reset mid-count: RESET_N pulsed low while KEY0's counter=2 -> all outputs immediately at reset values; with KEY0 still held, the press is accepted only after full synchronization plus 4 cycles from release.
